// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - 16-row reservation station with wakeup tracking and per-FU issue select
// Define RS_OLDEST_FIRST_EN for age-matrix (oldest-first) select; default is lowest-index-first.
module rs_issue_queue #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4,
  parameter int NUM_FU = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               disp_valid,
  input  logic [13:0]              disp_op,
  input  logic [2*PREG_W-1:0]      disp_pd,
  input  logic [2*PREG_W-1:0]      disp_ps1,
  input  logic [2*PREG_W-1:0]      disp_ps2,
  input  logic [1:0]               disp_ps1_rdy,
  input  logic [1:0]               disp_ps2_rdy,
  input  logic [3:0]               disp_fu,
  input  logic [2*ROB_W-1:0]       disp_rob,
  output logic                     disp_ready,
  input  logic [1:0]               wb_valid,
  input  logic [2*PREG_W-1:0]      wb_tag,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        iss_valid,
  output logic [NUM_FU*7-1:0]      iss_op,
  output logic [NUM_FU*PREG_W-1:0] iss_pd,
  output logic [NUM_FU*PREG_W-1:0] iss_ps1,
  output logic [NUM_FU*PREG_W-1:0] iss_ps2,
  output logic [NUM_FU*ROB_W-1:0]  iss_rob,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int OP_W  = 7;
  localparam int FU_W  = 2;

  logic [DEPTH-1:0]         in_use_q, in_use_d;
  logic [DEPTH-1:0]         src1_rdy_q, src1_rdy_d;
  logic [DEPTH-1:0]         src2_rdy_q, src2_rdy_d;
  logic [OP_W-1:0]          op_q  [DEPTH];
  logic [OP_W-1:0]          op_d  [DEPTH];
  logic [PREG_W-1:0]        pd_q  [DEPTH];
  logic [PREG_W-1:0]        pd_d  [DEPTH];
  logic [PREG_W-1:0]        ps1_q [DEPTH];
  logic [PREG_W-1:0]        ps1_d [DEPTH];
  logic [PREG_W-1:0]        ps2_q [DEPTH];
  logic [PREG_W-1:0]        ps2_d [DEPTH];
  logic [FU_W-1:0]          fu_q  [DEPTH];
  logic [FU_W-1:0]          fu_d  [DEPTH];
  logic [ROB_W-1:0]         rob_q [DEPTH];
  logic [ROB_W-1:0]         rob_d [DEPTH];

  logic [NUM_FU-1:0]        iss_valid_q, iss_valid_d;
  logic [NUM_FU*OP_W-1:0]   iss_op_q, iss_op_d;
  logic [NUM_FU*PREG_W-1:0] iss_pd_q, iss_pd_d;
  logic [NUM_FU*PREG_W-1:0] iss_ps1_q, iss_ps1_d;
  logic [NUM_FU*PREG_W-1:0] iss_ps2_q, iss_ps2_d;
  logic [NUM_FU*ROB_W-1:0]  iss_rob_q, iss_rob_d;
  logic [CNT_W-1:0]         occ_q, occ_d;

  logic [DEPTH-1:0]         elig [NUM_FU];
  logic [NUM_FU-1:0]        sel_valid;
  logic [IDX_W-1:0]         sel_idx [NUM_FU];
  logic [CNT_W-1:0]         free_cnt;
  logic [IDX_W-1:0]         free_lo, free_next;
  logic                     lo_found, next_found;
  logic [1:0]               disp_we;
  logic [IDX_W-1:0]         lane_row [2];
  logic [CNT_W-1:0]         iss_cnt;

  function automatic logic wb_hit(input logic [PREG_W-1:0] tag, input logic [1:0] v,
                                  input logic [2*PREG_W-1:0] tags);
    return (v[0] && (tags[PREG_W-1:0] == tag)) || (v[1] && (tags[2*PREG_W-1:PREG_W] == tag));
  endfunction

  // Only rows free at the start of the cycle count; rows issuing now are reusable next cycle.
  always_comb begin
    free_cnt   = '0;
    free_lo    = '0;
    free_next  = '0;
    lo_found   = 1'b0;
    next_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!in_use_q[i]) begin
        free_cnt = free_cnt + CNT_W'(1);
        if (!lo_found) begin
          free_lo  = IDX_W'(i);
          lo_found = 1'b1;
        end else if (!next_found) begin
          free_next  = IDX_W'(i);
          next_found = 1'b1;
        end
      end
    end
    disp_ready  = (free_cnt >= CNT_W'(2)) && !flush;
    disp_we     = disp_valid & {2{disp_ready}};
    lane_row[0] = free_lo;
    lane_row[1] = disp_we[0] ? free_next : free_lo;
  end

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        elig[k][i] = in_use_q[i] && src1_rdy_q[i] && src2_rdy_q[i]
                     && fu_ready[k] && (int'(fu_q[i]) == k);
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // older_q[i][j] set means row j was allocated before row i.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      sel_valid[k] = 1'b0;
      sel_idx[k]   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (elig[k][i] && ((elig[k] & older_q[i]) == '0)) begin
          sel_valid[k] = 1'b1;
          sel_idx[k]   = IDX_W'(i);
        end
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      sel_valid[k] = 1'b0;
      sel_idx[k]   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (elig[k][i]) begin
          sel_valid[k] = 1'b1;
          sel_idx[k]   = IDX_W'(i);
        end
      end
    end
  end
`endif

  always_comb begin
    in_use_d    = in_use_q;
    src1_rdy_d  = src1_rdy_q;
    src2_rdy_d  = src2_rdy_q;
    op_d        = op_q;
    pd_d        = pd_q;
    ps1_d       = ps1_q;
    ps2_d       = ps2_q;
    fu_d        = fu_q;
    rob_d       = rob_q;
    iss_valid_d = '0;
    iss_op_d    = iss_op_q;
    iss_pd_d    = iss_pd_q;
    iss_ps1_d   = iss_ps1_q;
    iss_ps2_d   = iss_ps2_q;
    iss_rob_d   = iss_rob_q;
    iss_cnt     = '0;
`ifdef RS_OLDEST_FIRST_EN
    older_d     = older_q;
`endif

    for (int i = 0; i < DEPTH; i++) begin
      if (in_use_q[i] && wb_hit(ps1_q[i], wb_valid, wb_tag)) src1_rdy_d[i] = 1'b1;
      if (in_use_q[i] && wb_hit(ps2_q[i], wb_valid, wb_tag)) src2_rdy_d[i] = 1'b1;
    end

    for (int k = 0; k < NUM_FU; k++) begin
      if (sel_valid[k] && !flush) begin
        in_use_d[sel_idx[k]]           = 1'b0;
        iss_valid_d[k]                 = 1'b1;
        iss_op_d[k*OP_W +: OP_W]       = op_q[sel_idx[k]];
        iss_pd_d[k*PREG_W +: PREG_W]   = pd_q[sel_idx[k]];
        iss_ps1_d[k*PREG_W +: PREG_W]  = ps1_q[sel_idx[k]];
        iss_ps2_d[k*PREG_W +: PREG_W]  = ps2_q[sel_idx[k]];
        iss_rob_d[k*ROB_W +: ROB_W]    = rob_q[sel_idx[k]];
        iss_cnt                        = iss_cnt + CNT_W'(1);
      end
    end

    // Same-cycle writeback is folded into the captured ready bits so no wakeup is lost.
    for (int l = 0; l < 2; l++) begin
      if (disp_we[l]) begin
        in_use_d[lane_row[l]]   = 1'b1;
        op_d[lane_row[l]]       = disp_op[l*OP_W +: OP_W];
        pd_d[lane_row[l]]       = disp_pd[l*PREG_W +: PREG_W];
        ps1_d[lane_row[l]]      = disp_ps1[l*PREG_W +: PREG_W];
        ps2_d[lane_row[l]]      = disp_ps2[l*PREG_W +: PREG_W];
        fu_d[lane_row[l]]       = disp_fu[l*FU_W +: FU_W];
        rob_d[lane_row[l]]      = disp_rob[l*ROB_W +: ROB_W];
        src1_rdy_d[lane_row[l]] = disp_ps1_rdy[l]
                                  || (disp_ps1[l*PREG_W +: PREG_W] == '0)
                                  || wb_hit(disp_ps1[l*PREG_W +: PREG_W], wb_valid, wb_tag);
        src2_rdy_d[lane_row[l]] = disp_ps2_rdy[l]
                                  || (disp_ps2[l*PREG_W +: PREG_W] == '0)
                                  || wb_hit(disp_ps2[l*PREG_W +: PREG_W], wb_valid, wb_tag);
`ifdef RS_OLDEST_FIRST_EN
        for (int j = 0; j < DEPTH; j++) older_d[j][lane_row[l]] = 1'b0;
        older_d[lane_row[l]] = ~(DEPTH'(1) << lane_row[l]);
`endif
      end
    end

    occ_d = occ_q + CNT_W'(disp_we[0]) + CNT_W'(disp_we[1]) - iss_cnt;
    if (flush) begin
      in_use_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_use_q    <= '0;
      iss_valid_q <= '0;
      iss_op_q    <= '0;
      iss_pd_q    <= '0;
      iss_ps1_q   <= '0;
      iss_ps2_q   <= '0;
      iss_rob_q   <= '0;
      occ_q       <= '0;
    end else begin
      in_use_q    <= in_use_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_pd_q    <= iss_pd_d;
      iss_ps1_q   <= iss_ps1_d;
      iss_ps2_q   <= iss_ps2_d;
      iss_rob_q   <= iss_rob_d;
      occ_q       <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    src1_rdy_q <= src1_rdy_d;
    src2_rdy_q <= src2_rdy_d;
    op_q       <= op_d;
    pd_q       <= pd_d;
    ps1_q      <= ps1_d;
    ps2_q      <= ps2_d;
    fu_q       <= fu_d;
    rob_q      <= rob_d;
`ifdef RS_OLDEST_FIRST_EN
    older_q    <= older_d;
`endif
  end

  // A row targeting a nonexistent FU can never be selected and would be stranded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < 2; l++) begin
        if (disp_we[l]) assert (int'(disp_fu[l*FU_W +: FU_W]) < NUM_FU);
      end
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_op    = iss_op_q;
  assign iss_pd    = iss_pd_q;
  assign iss_ps1   = iss_ps1_q;
  assign iss_ps2   = iss_ps2_q;
  assign iss_rob   = iss_rob_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb/tb_rs_issue_queue.sv - directed plus randomized bench with a row-level reference model
// Expected select order follows RS_OLDEST_FIRST_EN when the macro is defined.
module tb_rs_issue_queue;
  localparam int DEPTH  = 16;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 4;
  localparam int NUM_FU = 3;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  disp_valid;
  logic [13:0] disp_op;
  logic [11:0] disp_pd, disp_ps1, disp_ps2;
  logic [1:0]  disp_ps1_rdy, disp_ps2_rdy;
  logic [3:0]  disp_fu;
  logic [7:0]  disp_rob;
  logic        disp_ready;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [2:0]  fu_ready;
  logic [2:0]  iss_valid;
  logic [20:0] iss_op;
  logic [17:0] iss_pd, iss_ps1, iss_ps2;
  logic [11:0] iss_rob;
  logic [4:0]  occupancy;

  always #5 clk = ~clk;

  rs_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .NUM_FU(NUM_FU)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_pd(disp_pd),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_fu(disp_fu), .disp_rob(disp_rob), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_pd(iss_pd),
    .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_rob(iss_rob),
    .occupancy(occupancy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       busy;
    logic [6:0] op;
    logic [5:0] pd, ps1, ps2;
    logic       r1, r2;
    int         fu;
    logic [3:0] rob;
    int         seq;
  } row_t;

  row_t       m_row [DEPTH];
  logic [2:0] m_iss_valid;
  logic [6:0] m_iss_op  [NUM_FU];
  logic [5:0] m_iss_pd  [NUM_FU];
  logic [5:0] m_iss_ps1 [NUM_FU];
  logic [5:0] m_iss_ps2 [NUM_FU];
  logic [3:0] m_iss_rob [NUM_FU];
  int         m_occ;
  int         m_seq = 0;

  function automatic bit m_wb(input logic [5:0] t);
    return (wb_valid[0] && wb_tag[5:0] == t) || (wb_valid[1] && wb_tag[11:6] == t);
  endfunction

  task automatic model_step();
    int fr[$];
    int pick [NUM_FU];
    int slot;
    int r;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m_row[i].busy = 1'b0;
      m_iss_valid = '0;
      m_occ = 0;
      if (rst) begin
        for (int k = 0; k < NUM_FU; k++) begin
          m_iss_op[k] = '0; m_iss_pd[k] = '0; m_iss_ps1[k] = '0;
          m_iss_ps2[k] = '0; m_iss_rob[k] = '0;
        end
      end
      return;
    end
    for (int i = 0; i < DEPTH; i++) if (!m_row[i].busy) fr.push_back(i);
    for (int k = 0; k < NUM_FU; k++) begin
      pick[k] = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_row[i].busy && m_row[i].r1 && m_row[i].r2 && m_row[i].fu == k && fu_ready[k]) begin
`ifdef RS_OLDEST_FIRST_EN
          if (pick[k] < 0 || m_row[i].seq < m_row[pick[k]].seq) pick[k] = i;
`else
          if (pick[k] < 0) pick[k] = i;
`endif
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_row[i].busy && m_wb(m_row[i].ps1)) m_row[i].r1 = 1'b1;
      if (m_row[i].busy && m_wb(m_row[i].ps2)) m_row[i].r2 = 1'b1;
    end
    m_iss_valid = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (pick[k] >= 0) begin
        m_iss_valid[k] = 1'b1;
        m_iss_op[k]  = m_row[pick[k]].op;
        m_iss_pd[k]  = m_row[pick[k]].pd;
        m_iss_ps1[k] = m_row[pick[k]].ps1;
        m_iss_ps2[k] = m_row[pick[k]].ps2;
        m_iss_rob[k] = m_row[pick[k]].rob;
        m_row[pick[k]].busy = 1'b0;
        m_occ--;
      end
    end
    if (fr.size() >= 2) begin
      slot = 0;
      for (int l = 0; l < 2; l++) begin
        if (disp_valid[l]) begin
          r = fr[slot];
          slot++;
          m_row[r].busy = 1'b1;
          m_row[r].op   = disp_op[l*7 +: 7];
          m_row[r].pd   = disp_pd[l*6 +: 6];
          m_row[r].ps1  = disp_ps1[l*6 +: 6];
          m_row[r].ps2  = disp_ps2[l*6 +: 6];
          m_row[r].r1   = disp_ps1_rdy[l] || m_row[r].ps1 == 0 || m_wb(m_row[r].ps1);
          m_row[r].r2   = disp_ps2_rdy[l] || m_row[r].ps2 == 0 || m_wb(m_row[r].ps2);
          m_row[r].fu   = int'(disp_fu[l*2 +: 2]);
          m_row[r].rob  = disp_rob[l*4 +: 4];
          m_row[r].seq  = m_seq;
          m_seq++;
          m_occ++;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  logic [20:0] e_op;
  logic [17:0] e_pd, e_ps1, e_ps2;
  logic [11:0] e_rob;
  int          e_free;

  always @(negedge clk) begin
    if (chk_en) begin
      e_free = 0;
      for (int i = 0; i < DEPTH; i++) if (!m_row[i].busy) e_free++;
      for (int k = 0; k < NUM_FU; k++) begin
        e_op[k*7 +: 7]  = m_iss_op[k];
        e_pd[k*6 +: 6]  = m_iss_pd[k];
        e_ps1[k*6 +: 6] = m_iss_ps1[k];
        e_ps2[k*6 +: 6] = m_iss_ps2[k];
        e_rob[k*4 +: 4] = m_iss_rob[k];
      end
      cmp("occupancy", 32'(occupancy), 32'(m_occ));
      cmp("iss_valid", 32'(iss_valid), 32'(m_iss_valid));
      cmp("disp_ready", 32'(disp_ready), 32'((e_free >= 2) && !flush));
      cmp("iss_op", 32'(iss_op), 32'(e_op));
      cmp("iss_pd", 32'(iss_pd), 32'(e_pd));
      cmp("iss_ps1", 32'(iss_ps1), 32'(e_ps1));
      cmp("iss_ps2", 32'(iss_ps2), 32'(e_ps2));
      cmp("iss_rob", 32'(iss_rob), 32'(e_rob));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input int op, input int pd, input int ps1, input int ps2,
                          input bit r1, input bit r2, input int fu, input int rob);
    disp_op[l*7 +: 7]  = 7'(op);
    disp_pd[l*6 +: 6]  = 6'(pd);
    disp_ps1[l*6 +: 6] = 6'(ps1);
    disp_ps2[l*6 +: 6] = 6'(ps2);
    disp_ps1_rdy[l]    = r1;
    disp_ps2_rdy[l]    = r2;
    disp_fu[l*2 +: 2]  = 2'(fu);
    disp_rob[l*4 +: 4] = 4'(rob);
  endtask

  int got[$];
  int exp_order [4];

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = '0; disp_op = '0; disp_pd = '0;
    disp_ps1 = '0; disp_ps2 = '0; disp_ps1_rdy = '0; disp_ps2_rdy = '0;
    disp_fu = '0; disp_rob = '0; wb_valid = '0; wb_tag = '0; fu_ready = 3'b111;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    cmp("reset_occupancy", 32'(occupancy), 0);
    cmp("reset_iss_valid", 32'(iss_valid), 0);
    cmp("reset_iss_pd", 32'(iss_pd), 0);
    cmp("reset_disp_ready", 32'(disp_ready), 1);

    // Single ready instruction: issues on the edge after the dispatch edge.
    set_lane(0, 7'b0110011, 33, 1, 2, 1, 1, 0, 0);
    disp_valid = 2'b01;
    tick();
    disp_valid = 2'b00;
    cmp("t1_occ_after_dispatch", 32'(occupancy), 1);
    cmp("t1_no_issue_same_cycle", 32'(iss_valid), 0);
    tick();
    cmp("t1_iss_valid", 32'(iss_valid), 3'b001);
    cmp("t1_iss_pd", 32'(iss_pd[5:0]), 33);
    cmp("t1_iss_rob", 32'(iss_rob[3:0]), 0);
    cmp("t1_occ_after_issue", 32'(occupancy), 0);

    // Pending source woken later; tag 0 on ps2 counts as ready.
    set_lane(0, 7'h13, 34, 33, 0, 0, 0, 0, 1);
    disp_valid = 2'b01;
    tick();
    disp_valid = 2'b00;
    tick();
    tick();
    cmp("t2_waiting", 32'(iss_valid), 0);
    wb_valid = 2'b01;
    wb_tag = 12'd33;
    tick();
    wb_valid = 2'b00;
    cmp("t2_not_early", 32'(iss_valid[0]), 0);
    tick();
    cmp("t2_issue", 32'(iss_valid[0]), 1);
    cmp("t2_iss_pd", 32'(iss_pd[5:0]), 34);

    // Same-cycle wakeup bypass on the dispatching row.
    set_lane(0, 7'h23, 35, 0, 40, 1, 0, 0, 2);
    disp_valid = 2'b01;
    wb_valid = 2'b10;
    wb_tag = {6'd40, 6'd7};
    tick();
    disp_valid = 2'b00;
    wb_valid = 2'b00;
    tick();
    cmp("t3_bypass_issue", 32'(iss_valid[0]), 1);
    cmp("t3_iss_pd", 32'(iss_pd[5:0]), 35);

    // Fill on a stalled FU until dispatch backpressures.
    fu_ready = 3'b011;
    for (int i = 0; i < 20 && disp_ready; i++) begin
      set_lane(0, i, i, 1, 2, 1, 1, 2, i);
      disp_valid = 2'b01;
      tick();
    end
    disp_valid = 2'b00;
    cmp("t4_full_occ", 32'(occupancy), 15);
    cmp("t4_ready_low", 32'(disp_ready), 0);
    fu_ready = 3'b111;
    tick();
    cmp("t4_first_issue", 32'(iss_valid), 3'b100);
    cmp("t4_first_rob", 32'(iss_rob[11:8]), 0);
    cmp("t4_occ_14", 32'(occupancy), 14);
    cmp("t4_ready_back", 32'(disp_ready), 1);
    repeat (16) tick();
    cmp("t4_drained", 32'(occupancy), 0);

    // Flush with a pair dispatching: both dropped.
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 1, 10 + 2*i, 60, 0, 0, 1, 0, 2*i);
      set_lane(1, 1, 11 + 2*i, 60, 0, 0, 1, 0, 2*i + 1);
      disp_valid = 2'b11;
      tick();
    end
    cmp("t5_occ_8", 32'(occupancy), 8);
    flush = 1'b1;
    #1;
    cmp("t5_ready_low_in_flush", 32'(disp_ready), 0);
    tick();
    flush = 1'b0;
    disp_valid = 2'b00;
    cmp("t5_occ_flushed", 32'(occupancy), 0);
    cmp("t5_no_issue", 32'(iss_valid), 0);
    tick();
    cmp("t5_occ_stays_0", 32'(occupancy), 0);

    // Reused low row versus older higher rows on fu 1.
    set_lane(0, 2, 20, 1, 2, 1, 1, 0, 8);
    set_lane(1, 2, 21, 50, 0, 0, 1, 1, 1);
    disp_valid = 2'b11;
    tick();
    set_lane(0, 2, 22, 50, 0, 0, 1, 1, 2);
    set_lane(1, 2, 23, 50, 0, 0, 1, 1, 3);
    tick();
    set_lane(0, 2, 24, 50, 0, 0, 1, 1, 4);
    disp_valid = 2'b01;
    tick();
    disp_valid = 2'b00;
    wb_valid = 2'b01;
    wb_tag = 12'd50;
    tick();
    wb_valid = 2'b00;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (iss_valid[1]) got.push_back(int'(iss_rob[7:4]));
    end
`ifdef RS_OLDEST_FIRST_EN
    exp_order = '{1, 2, 3, 4};
`else
    exp_order = '{4, 1, 2, 3};
`endif
    cmp("t6_issue_count", 32'(got.size()), 4);
    for (int i = 0; i < 4; i++) begin
      cmp($sformatf("t6_order_%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hff, 32'(exp_order[i]));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      disp_valid = 2'($urandom_range(0, 3));
      for (int l = 0; l < 2; l++) begin
        set_lane(l, int'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 2)), int'($urandom));
      end
      wb_valid = 2'($urandom_range(0, 3));
      wb_tag = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      fu_ready = 3'($urandom);
      flush = ($urandom_range(0, 63) == 0);
      rst = (c == 1500);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    disp_valid = 2'b00;
    wb_valid = 2'b00;
    tick();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
